// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms and cin, not chained through lower carries.
module cla_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  always_comb begin
    logic        cc;
    logic        pp;
    int unsigned j;
    g    = in1 & in2;
    p    = in1 ^ in2;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      cc = 1'b0;
      pp = 1'b1;
      for (int unsigned k = 0; k <= i; k++) begin
        j  = i - k;
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
    out  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one add/shift per cycle
// through cla_adder, start/busy/done handshake, registered product.
module seq_mult_shift_add
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     q_q;
  logic [CNT_W-1:0]     count_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [WIDTH-1:0]     a_d;
  logic [WIDTH-1:0]     q_d;

  always_comb addend = q_q[0] ? m_q : '0;

  cla_adder #(.WIDTH(WIDTH)) u_adder (
    .in1  (a_q),
    .in2  (addend),
    .cin  (1'b0),
    .out  (sum),
    .cout (cout)
  );

  // The adder carry lands straight in A's MSB, so no separate C flop is kept.
  always_comb begin
    a_d = {cout, sum[WIDTH-1:1]};
    q_d = {sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= in1;
            q_q     <= in2;
            a_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          q_q     <= q_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            product_q <= {a_d, q_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
